// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit.
// Operation codes, controller states and the iteration count.
package muldiv_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU,
    MD_MTHI,
    MD_MTLO
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } md_state_t;

  localparam int MD_ITERS = 32;

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// One restoring division iteration.
// Shifts the next dividend bit in from the quotient register's MSB.
module div_step
  import muldiv_pkg::*;
(
  input  logic [32:0] rem_i,
  input  word_t       quo_i,
  input  word_t       dvs_i,
  output logic [32:0] rem_o,
  output word_t       quo_o
);

  logic [33:0] sh;
  logic        ge;

  always_comb begin
    sh = {rem_i, quo_i[31]};
    ge = sh >= {2'b00, dvs_i};
    rem_o = 33'(ge ? sh - {2'b00, dvs_i} : sh);
    quo_o = {quo_i[30:0], ge};
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO controller: iterative divider, optional iterative multiplier.
// Define MULDIV_MULT_ITER_EN to run MULT/MULTU through the 32-cycle path.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  muldiv_op_t op,
  input  word_t      a,
  input  word_t      b,
  input  logic       flush,
  output logic       stall_req,
  output word_t      hi,
  output word_t      lo
);

  md_state_t   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d, drem;
  word_t       quo_q, quo_d, dquo;
  word_t       dvs_q, dvs_d;
  logic        mul_q, mul_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  word_t       hi_q, hi_d, lo_q, lo_d;

  logic        is_sgn, is_div, is_mul, multi, last;
  word_t       abs_a, abs_b;
  logic [32:0] msum, srem;
  word_t       squo, res_hi, res_lo;
  logic [63:0] prod;
`ifndef MULDIV_MULT_ITER_EN
  logic [63:0] xa, xb, cprod;
`endif

  div_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (drem),
    .quo_o (dquo)
  );

  always_comb begin
    is_sgn = (op == MD_MULT) | (op == MD_DIV);
    is_div = (op == MD_DIV) | (op == MD_DIVU);
    is_mul = (op == MD_MULT) | (op == MD_MULTU);
`ifdef MULDIV_MULT_ITER_EN
    multi = is_div | is_mul;
`else
    multi = is_div;
`endif
    abs_a = (is_sgn & a[31]) ? -a : a;
    abs_b = (is_sgn & b[31]) ? -b : b;
    last  = (state_q == BUSY) && (cnt_q == 5'(MD_ITERS - 1));
  end

`ifndef MULDIV_MULT_ITER_EN
  // Sign-extend first so one unsigned 64-bit multiply serves both ops.
  always_comb begin
    xa = is_sgn ? {{32{a[31]}}, a} : {32'd0, a};
    xb = is_sgn ? {{32{b[31]}}, b} : {32'd0, b};
    cprod = xa * xb;
  end
`endif

  // Shift-add: rem_q holds product high half, quo_q the multiplier.
  always_comb begin
    msum = {1'b0, rem_q[31:0]} + (quo_q[0] ? {1'b0, dvs_q} : 33'd0);
    srem = mul_q ? {1'b0, msum[32:1]} : drem;
    squo = mul_q ? {msum[0], quo_q[31:1]} : dquo;
    prod = {srem[31:0], squo};
    if (negq_q) prod = -prod;
    if (mul_q) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else begin
      res_hi = negr_q ? -srem[31:0] : srem[31:0];
      res_lo = negq_q ? -squo : squo;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    mul_d   = mul_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (1'b1)
      state_q == IDLE: begin
        if (start) begin
          if (multi) begin
            state_d = BUSY;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = abs_a;
            dvs_d   = abs_b;
            mul_d   = is_mul;
            negq_d  = is_sgn & (a[31] ^ b[31]);
            negr_d  = is_sgn & a[31];
          end else if (op == MD_MTHI) begin
            hi_d = a;
          end else if (op == MD_MTLO) begin
            lo_d = a;
`ifndef MULDIV_MULT_ITER_EN
          end else if (is_mul) begin
            hi_d = cprod[63:32];
            lo_d = cprod[31:0];
`endif
          end
        end
      end
      state_q == BUSY: begin
        rem_d = srem;
        quo_d = squo;
        cnt_d = cnt_q + 5'd1;
        if (last) begin
          state_d = DONE;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      mul_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      mul_q   <= mul_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign stall_req = ~flush &
    (((state_q == IDLE) & start & multi) | (state_q == BUSY));
  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: directed and random ops vs. arithmetic model.
// Mult stall expectation follows MULDIV_MULT_ITER_EN.
module tb_muldiv_ctrl;
  import muldiv_pkg::word_t;
  import muldiv_pkg::muldiv_op_t;
  import muldiv_pkg::MD_MULT;
  import muldiv_pkg::MD_MULTU;
  import muldiv_pkg::MD_DIV;
  import muldiv_pkg::MD_DIVU;
  import muldiv_pkg::MD_MTHI;
  import muldiv_pkg::MD_MTLO;

`ifdef MULDIV_MULT_ITER_EN
  localparam int MUL_STALL = 33;
`else
  localparam int MUL_STALL = 0;
`endif

  logic       clk;
  logic       resetn;
  logic       start;
  muldiv_op_t op;
  word_t      a;
  word_t      b;
  logic       flush;
  logic       stall_req;
  word_t      hi;
  word_t      lo;

  int    n_cmp;
  int    n_err;
  word_t m_hi;
  word_t m_lo;

  muldiv_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] udiv(input word_t x, input word_t y);
    if (y == 0) return {x, 32'hFFFF_FFFF};
    return {x % y, x / y};
  endfunction

  // Returns {hi, lo} after the op, from the architectural rules.
  function automatic logic [63:0] ref_op(input muldiv_op_t o,
                                         input word_t x, input word_t y);
    logic signed [63:0] sx, sy;
    logic [63:0] r;
    word_t mx, my, q, rm;
    case (o)
      MD_MULT: begin
        sx = $signed(x);
        sy = $signed(y);
        return sx * sy;
      end
      MD_MULTU: return {32'd0, x} * {32'd0, y};
      MD_DIVU: return udiv(x, y);
      MD_DIV: begin
        mx = x[31] ? 32'd0 - x : x;
        my = y[31] ? 32'd0 - y : y;
        r  = udiv(mx, my);
        q  = (x[31] != y[31]) ? 32'd0 - r[31:0] : r[31:0];
        rm = x[31] ? 32'd0 - r[63:32] : r[63:32];
        return {rm, q};
      end
      MD_MTHI: return {x, m_lo};
      default: return {m_hi, x};
    endcase
  endfunction

  function automatic int exp_stall(input muldiv_op_t o);
    if (o == MD_DIV || o == MD_DIVU) return 33;
    if (o == MD_MULT || o == MD_MULTU) return MUL_STALL;
    return 0;
  endfunction

  // Called ~1ns after a rising edge; returns at the same phase.
  task automatic issue(input muldiv_op_t o, input word_t x, input word_t y,
                       input string tag);
    logic [63:0] r;
    int n;
    r = ref_op(o, x, y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    #1;
    n = 0;
    while (stall_req === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    #1;
    m_hi = r[63:32];
    m_lo = r[31:0];
    chk({tag, "_stall"}, n, exp_stall(o));
    chk({tag, "_hi"}, hi, m_hi);
    chk({tag, "_lo"}, lo, m_lo);
    chk({tag, "_idle"}, {31'd0, stall_req}, 32'd0);
  endtask

  initial begin
    muldiv_op_t ro;
    word_t ra, rb;
    n_cmp = 0;
    n_err = 0;
    m_hi = '0;
    m_lo = '0;
    resetn = 1'b0;
    start = 1'b0;
    op = MD_MTHI;
    a = '0;
    b = '0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    issue(MD_DIVU, 32'd100, 32'd7, "divu100_7");
    chk("divu100_7_q", lo, 32'd14);
    chk("divu100_7_r", hi, 32'd2);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    chk("div_m7_2_q", lo, 32'hFFFF_FFFD);
    chk("div_m7_2_r", hi, 32'hFFFF_FFFF);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    chk("multu_max_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo, 32'h0000_0001);
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, "mult_m2_3");
    chk("mult_m2_3_lo", lo, 32'hFFFF_FFFA);
    issue(MD_DIVU, 32'd5, 32'd0, "divu_5_0");
    chk("divu_5_0_q", lo, 32'hFFFF_FFFF);
    issue(MD_DIV, 32'hFFFF_FFFC, 32'd0, "div_m4_0");
    chk("div_m4_0_q", lo, 32'd1);
    chk("div_m4_0_r", hi, 32'hFFFF_FFFC);
    issue(MD_MTHI, 32'd0, 32'd0, "mthi0");
    issue(MD_MTHI, 32'h0000_1234, 32'd0, "mthi1234");
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");

    // Flush during BUSY
    issue(MD_MTHI, 32'hA5A5_A5A5, 32'd0, "pre_hi");
    issue(MD_MTLO, 32'hA5A5_A5A5, 32'd0, "pre_lo");
    start = 1'b1;
    op = MD_DIV;
    a = 32'h0123_4567;
    b = 32'd3;
    repeat (11) @(posedge clk);
    #1;
    chk("busy_stall", {31'd0, stall_req}, 32'd1);
    flush = 1'b1;
    #1;
    chk("flush_stall", {31'd0, stall_req}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    #1;
    chk("flush_idle", {31'd0, stall_req}, 32'd0);
    chk("flush_hi", hi, 32'hA5A5_A5A5);
    chk("flush_lo", lo, 32'hA5A5_A5A5);
    issue(MD_DIVU, 32'd1000, 32'd33, "after_flush");

    // Flush in IDLE suppresses MTHI
    start = 1'b1;
    op = MD_MTHI;
    a = 32'hDEAD_BEEF;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    #1;
    chk("flush_mthi", hi, m_hi);

    // Reset mid-operation
    start = 1'b1;
    op = MD_DIVU;
    a = 32'd77;
    b = 32'd5;
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    resetn = 1'b1;
    #1;
    m_hi = '0;
    m_lo = '0;
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_stall", {31'd0, stall_req}, 32'd0);
    issue(MD_DIV, 32'hFFFF_FF00, 32'd7, "after_rst");

    for (int i = 0; i < 24; i++) begin
      ro = muldiv_op_t'($urandom_range(0, 5));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
      issue(ro, ra, rb, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle HI/LO unit controller for the execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the issuing stage and sequences a radix-2 restoring divider, plus optionally an iterative shift-add multiplier. It owns the architectural HI/LO registers and raises a stall request to the hazard unit while an operation is in flight. A pipeline flush aborts any in-flight operation without side effects.

## Interface
- No parameters; data width fixed at 32 (word_t).
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- start  in  1  valid request from execute stage; held with op/a/b while stall_req is high
- op  in  muldiv_op_t  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
- a  in  32  rs operand (dividend / multiplicand / MTHI/MTLO source)
- b  in  32  rt operand (divisor / multiplier)
- flush  in  1  hazard flush of execute stage; aborts the current operation
- stall_req  out  1  to hazard unit; stall execute stage and everything upstream
- hi  out  32  registered HI
- lo  out  32  registered LO

## Operation
- States: IDLE, BUSY, DONE.
- Reset: state IDLE, counter 0, hi=lo=0, stall_req=0.
- IDLE:
  - start with MTHI: write hi<=a at the edge. MTLO: write lo<=a. No stall.
  - start with DIV/DIVU: latch operand magnitudes (abs() for signed ops), latch the quotient and remainder sign flags, clear the counter, go to BUSY.
  - MULT/MULTU follow the same path when MULT_ITER_EN is defined.
- BUSY: one restoring step per cycle, counter 0..31. On the edge where counter==31, apply the sign fix and write hi/lo, then go to DONE.
- DONE: one cycle. start is ignored, because it is the same instruction now advancing. Go to IDLE.
- stall_req = (state==IDLE & start & multi-cycle op) | (state==BUSY). It is combinational from start, and it is low in DONE.
- Signed result rules:
  - Quotient is negated if sign(a)^sign(b).
  - Remainder takes sign(a).
  - Product is negated if sign(a)^sign(b).
  - Unsigned ops use no abs and no fix.
- Divide by zero is defined:
  - Unsigned path yields quotient 0xFFFFFFFF, remainder = |a|.
  - The signed fix then applies. For example, DIV -4/0 gives lo=1 and hi=-4.
- Result mapping: mult gives hi=product[63:32], lo=product[31:0]. Div gives lo=quotient, hi=remainder.
- Priority: flush > everything.
  - flush in any state: state<=IDLE, counter<=0, no hi/lo write.
  - flush in IDLE with start set suppresses MTHI/MTLO writes too.
  - stall_req is forced low while flush is high.
- resetn low mid-operation behaves like flush, and additionally clears hi/lo.
- hi/lo have no bypass. A reader sees the new value the cycle after the write edge; the hazard unit handles MFHI/MFLO ordering.

## Timing
- Multi-cycle op issued at cycle 0: stall_req is high in cycles 0..32 (33 cycles).
- hi/lo are written at the end of cycle 32, are visible in cycle 33 (DONE), and the instruction advances at the end of cycle 33.
- Back-to-back multi-cycle ops: the second start can be accepted at the earliest in cycle 34 (IDLE).
- MTHI/MTLO: zero stall; value visible the next cycle.
- Without MULT_ITER_EN, MULT/MULTU are single-cycle: zero stall, product written at the issue edge.

## Configuration
- MULDIV_MULT_ITER_EN:
  - Defined: multiplication uses the 32-cycle shift-add datapath, sharing the magnitude/sign-fix logic and FSM with the divider, with the same 33-cycle stall.
  - Undefined: MULT/MULTU use a combinational 32x32 multiply, never enter BUSY, and never stall. Division is unchanged.

## Structure
- Shared package muldiv_pkg holds:
  - muldiv_op_t enum;
  - md_state_t enum (IDLE/BUSY/DONE);
  - localparam MD_ITERS = 32.
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: partial remainder (33 bits), quotient, divisor.
  - Outputs: next partial remainder and next quotient.
  - Instantiated once; the controller holds all registers.

## Test plan
- DIVU a=100 b=7 -> stall_req high exactly 33 cycles, then lo=14 and hi=2.
- DIV a=-7 (0xFFFFFFF9) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT a=-2 b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Run both with and without MULT_ITER_EN; check the stall length is 33 and 0 respectively.
- DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=5. DIV a=-4 b=0 -> lo=1, hi=0xFFFFFFFC.
- MTHI a=0x1234 with HI=0 -> hi=0x1234 the next cycle, and stall_req is never asserted.
- Preload hi=lo=0xA5A5A5A5, start DIV, assert flush in BUSY cycle 10 -> stall_req low that cycle, state IDLE, hi/lo still 0xA5A5A5A5; a new DIVU issued next accepted normally.
